fp_exp_align_pipe: RTL and testbench
====================================

Name: fp_exp_align_pipe

Overview:
- Parametrised, pipelined successor to the combinational exponent-compare stage of the floating-point adder datapath.
- Compares two exponents and selects the larger one, reports which operand is smaller (swap flag), and computes the magnitude of the exponent difference.
- Right-shifts the smaller operand's mantissa into alignment, with guard/round/sticky bits.
- Sits between operand unpack and mantissa add/sub; two-stage pipeline with valid/ready handshake on both sides.

Parameters:
- EXP_W, 8, exponent width in bits.
- MAN_W, 24, mantissa width including hidden bit.
- GRS_W, 3, fixed at 3 (guard, round, sticky); aligned mantissa width is MAN_W+3.

Ports:
- clk  input  1  clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept operand pair this cycle.
- e1  input  EXP_W  exponent A.
- e2  input  EXP_W  exponent B.
- m1  input  MAN_W  mantissa A.
- m2  input  MAN_W  mantissa B.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- swap  output  1  0: e1>=e2 (A larger or equal); 1: e1<e2.
- diff  output  EXP_W  |e1-e2|.
- exp_max  output  EXP_W  larger exponent.
- man_big  output  MAN_W  mantissa of the larger-exponent operand.
- man_small_al  output  MAN_W+3  smaller mantissa aligned; bits [2:0] are G,R,S.
- diff_zero  output  1  diff==0.

Behaviour:
- Reset (async assert, sync deassert usage): all pipeline valid flags 0; out_valid=0; all data outputs 0; in_ready=1 after the first clk edge following deassert.
- Handshake:
  - Transfer in when in_valid&&in_ready.
  - Transfer out when out_valid&&out_ready.
  - Inputs are sampled only on an input transfer.
  - Outputs hold stable while out_valid&&!out_ready.
- Pipeline enables:
  - en2 = !out_valid || out_ready.
  - en1 = !s1_valid || en2.
  - in_ready = en1 (combinational from state and out_ready).
  - No bubble when out_ready is held at 1: full throughput, one result per cycle.
- Latency: exactly 2 cycles from input transfer to out_valid, absent stalls.
- Stage 1 (registered on en1):
  - If e1>=e2: swap=0, diff=e1-e2, exp_max=e1, big=m1, small=m2.
  - Else: swap=1, diff=e2-e1, exp_max=e2, big=m2, small=m1.
  - Equal exponents: swap=0.
  - s1_valid <= in_valid&&in_ready.
- Stage 2 (registered on en2):
  - Let x = {small,3'b000}.
  - If diff < MAN_W+3: man_small_al = (x >> diff) with bit0 ORed with the OR of all bits shifted out.
  - Else: man_small_al = {MAN_W+2 zeros, |small}.
  - Pass swap, diff, exp_max and man_big through unchanged; diff_zero = (diff==0).
  - out_valid <= s1_valid when en2.
- Width rules:
  - Subtraction is unsigned EXP_W-bit and never wraps, because the larger operand is always the minuend.
  - The shift amount uses the full EXP_W bits; shift saturation covers EXP_W up to 11.
- Simultaneous events:
  - Output transfer and input transfer in the same cycle with a full pipeline: both occur, no loss, no duplication.
  - in_valid deasserted mid-stream: bubble propagates, out_valid drops 2 cycles later.
- Reset mid-operation: in-flight data is discarded; out_valid=0 immediately on reset_n low (async).
- Data outputs when out_valid=0 are don't-care except after reset (0).

Test Plan:
- e1=0x85, e2=0x82, m1=0xC00000, m2=0x800000, out_ready=1 -> 2 cycles later:
  - swap=0, diff=3, exp_max=0x85, man_big=0xC00000.
  - man_small_al=27'h0800000, diff_zero=0.
- e1=0x10, e2=0x20, m1=0x800003, m2=0xA00000 -> swap=1, diff=16, exp_max=0x20, man_big=0xA00000, man_small_al=27'h0000401 (sticky set from shifted-out bits).
- e1=0xFF, e2=0x00, m2=0x800001 -> diff=255, man_small_al=27'h0000001 (saturated, sticky only); m2=0 gives 27'h0.
- e1=e2=0x7F, m1=0x900000, m2=0xF00000 -> swap=0, diff=0, diff_zero=1, man_big=0x900000, man_small_al=27'h7800000.
- Back-to-back stream of 4 pairs with out_ready=0 for cycles 2-6:
  - in_ready drops after 2 accepted pairs.
  - Outputs stay stable during the stall.
  - All 4 results emerge in order once out_ready=1, with no gaps while out_ready stays high.
- reset_n pulsed low for 1 cycle with 2 pairs in flight -> out_valid=0 at once, outputs=0, no stale result emerges afterwards, and the next accepted pair returns correctly 2 cycles after acceptance.

Source files
------------

// File: rtl/fp_exp_align_pipe.sv
// Two-stage exponent compare and mantissa alignment for the FP adder datapath.
// Stage 1 orders the operands by exponent; stage 2 right-shifts the smaller mantissa with G/R/S.
module fp_exp_align_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 24,
    parameter int GRS_W = 3
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [EXP_W-1:0]         e1,
    input  logic [EXP_W-1:0]         e2,
    input  logic [MAN_W-1:0]         m1,
    input  logic [MAN_W-1:0]         m2,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     swap,
    output logic [EXP_W-1:0]         diff,
    output logic [EXP_W-1:0]         exp_max,
    output logic [MAN_W-1:0]         man_big,
    output logic [MAN_W+GRS_W-1:0]   man_small_al,
    output logic                     diff_zero
);

    localparam int AL_W = MAN_W + GRS_W;

    logic             en1;
    logic             en2;

    logic             s1_valid_reg;
    logic             s1_swap_reg;
    logic [EXP_W-1:0] s1_diff_reg;
    logic [EXP_W-1:0] s1_exp_reg;
    logic [MAN_W-1:0] s1_big_reg;
    logic [MAN_W-1:0] s1_small_reg;

    logic             swap_next;
    logic [EXP_W-1:0] diff_next;
    logic [EXP_W-1:0] exp_next;
    logic [MAN_W-1:0] big_next;
    logic [MAN_W-1:0] small_next;

    logic             out_valid_reg;
    logic             swap_reg;
    logic [EXP_W-1:0] diff_reg;
    logic [EXP_W-1:0] exp_max_reg;
    logic [MAN_W-1:0] man_big_reg;
    logic [AL_W-1:0]  man_small_al_reg;
    logic             diff_zero_reg;

    logic [AL_W-1:0]  x_w;
    logic [AL_W-1:0]  shifted_w;
    logic [AL_W-1:0]  lost_w;
    logic             sat_w;
    logic [AL_W-1:0]  al_next;

    assign en2      = !out_valid_reg || out_ready;
    assign en1      = !s1_valid_reg || en2;
    assign in_ready = en1;

    // The larger exponent is always the minuend, so the subtraction never wraps.
    always_comb begin
        swap_next  = 1'b0;
        diff_next  = e1 - e2;
        exp_next   = e1;
        big_next   = m1;
        small_next = m2;
        if (e1 < e2) begin
            swap_next  = 1'b1;
            diff_next  = e2 - e1;
            exp_next   = e2;
            big_next   = m2;
            small_next = m1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_reg <= 1'b0;
            s1_swap_reg  <= 1'b0;
            s1_diff_reg  <= '0;
            s1_exp_reg   <= '0;
            s1_big_reg   <= '0;
            s1_small_reg <= '0;
        end else if (en1) begin
            s1_valid_reg <= in_valid;
            if (in_valid) begin
                s1_swap_reg  <= swap_next;
                s1_diff_reg  <= diff_next;
                s1_exp_reg   <= exp_next;
                s1_big_reg   <= big_next;
                s1_small_reg <= small_next;
            end
        end
    end

    assign x_w       = {s1_small_reg, {GRS_W{1'b0}}};
    assign shifted_w = x_w >> s1_diff_reg;
    assign sat_w     = 32'(s1_diff_reg) >= AL_W;

    // A bit is lost to the sticky when its position lies below the shift amount.
    genvar gi;
    generate
        for (gi = 0; gi < AL_W; gi = gi + 1) begin : g_lost
            assign lost_w[gi] = x_w[gi] && (32'(s1_diff_reg) > gi);
        end
    endgenerate

    always_comb begin
        al_next = {shifted_w[AL_W-1:1], shifted_w[0] | (|lost_w)};
        if (sat_w) begin
            al_next = {{(AL_W-1){1'b0}}, |s1_small_reg};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_reg    <= 1'b0;
            swap_reg         <= 1'b0;
            diff_reg         <= '0;
            exp_max_reg      <= '0;
            man_big_reg      <= '0;
            man_small_al_reg <= '0;
            diff_zero_reg    <= 1'b0;
        end else if (en2) begin
            out_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                swap_reg         <= s1_swap_reg;
                diff_reg         <= s1_diff_reg;
                exp_max_reg      <= s1_exp_reg;
                man_big_reg      <= s1_big_reg;
                man_small_al_reg <= al_next;
                diff_zero_reg    <= (s1_diff_reg == '0);
            end
        end
    end

    assign out_valid    = out_valid_reg;
    assign swap         = swap_reg;
    assign diff         = diff_reg;
    assign exp_max      = exp_max_reg;
    assign man_big      = man_big_reg;
    assign man_small_al = man_small_al_reg;
    assign diff_zero    = diff_zero_reg;

endmodule

// File: tb/tb_fp_exp_align_pipe.sv
// Directed-vector bench for fp_exp_align_pipe: table of single transactions plus stall and reset sequences.
module tb_fp_exp_align_pipe;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  e1, e2;
    logic [23:0] m1, m2;
    logic        out_valid;
    logic        out_ready;
    logic        swap;
    logic [7:0]  diff;
    logic [7:0]  exp_max;
    logic [23:0] man_big;
    logic [26:0] man_small_al;
    logic        diff_zero;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0]  e1;
        logic [7:0]  e2;
        logic [23:0] m1;
        logic [23:0] m2;
        logic        swap;
        logic [7:0]  diff;
        logic [7:0]  exp_max;
        logic [23:0] man_big;
        logic [26:0] al;
        logic        dz;
    } vec_t;

    localparam int NV = 7;
    vec_t vecs [NV];

    fp_exp_align_pipe dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .e1           (e1),
        .e2           (e2),
        .m1           (m1),
        .m2           (m2),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .swap         (swap),
        .diff         (diff),
        .exp_max      (exp_max),
        .man_big      (man_big),
        .man_small_al (man_small_al),
        .diff_zero    (diff_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_out(input int k, input string tag);
        chk({tag, "_swap"},  32'(swap),         32'(vecs[k].swap));
        chk({tag, "_diff"},  32'(diff),         32'(vecs[k].diff));
        chk({tag, "_emax"},  32'(exp_max),      32'(vecs[k].exp_max));
        chk({tag, "_big"},   32'(man_big),      32'(vecs[k].man_big));
        chk({tag, "_al"},    32'(man_small_al), 32'(vecs[k].al));
        chk({tag, "_dzero"}, 32'(diff_zero),    32'(vecs[k].dz));
        $display("txn %s vec=%0d swap=%0d diff=%0d exp_max=%0h man_big=%0h al=%0h dz=%0d",
                 tag, k, swap, diff, exp_max, man_big, man_small_al, diff_zero);
    endtask

    task automatic drive(input int k);
        e1 = vecs[k].e1;
        e2 = vecs[k].e2;
        m1 = vecs[k].m1;
        m2 = vecs[k].m2;
    endtask

    // Apply one pair with out_ready high and check the two-cycle latency.
    task automatic single(input int k);
        @(negedge clk);
        drive(k);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("single_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("single_lat1_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("single_lat2_valid", 32'(out_valid), 32'd1);
        check_out(k, "vec");
    endtask

    initial begin
        // {e1, e2, m1, m2, swap, diff, exp_max, man_big, al, diff_zero}
        vecs[0] = '{8'h85, 8'h82, 24'hC00000, 24'h800000, 1'b0, 8'd3,   8'h85, 24'hC00000, 27'h0800000, 1'b0};
        vecs[1] = '{8'h10, 8'h20, 24'h800003, 24'hA00000, 1'b1, 8'd16,  8'h20, 24'hA00000, 27'h0000401, 1'b0};
        vecs[2] = '{8'hFF, 8'h00, 24'hABCDEF, 24'h800001, 1'b0, 8'd255, 8'hFF, 24'hABCDEF, 27'h0000001, 1'b0};
        vecs[3] = '{8'hFF, 8'h00, 24'hABCDEF, 24'h000000, 1'b0, 8'd255, 8'hFF, 24'hABCDEF, 27'h0000000, 1'b0};
        vecs[4] = '{8'h7F, 8'h7F, 24'h900000, 24'hF00000, 1'b0, 8'd0,   8'h7F, 24'h900000, 27'h7800000, 1'b1};
        vecs[5] = '{8'h20, 8'h38, 24'hFFFFFF, 24'h800000, 1'b1, 8'd24,  8'h38, 24'h800000, 27'h0000007, 1'b0};
        vecs[6] = '{8'h3B, 8'h20, 24'hC00000, 24'h800000, 1'b0, 8'd27,  8'h3B, 24'hC00000, 27'h0000001, 1'b0};

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        e1 = '0; e2 = '0; m1 = '0; m2 = '0;

        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_al", 32'(man_small_al), 32'd0);
        chk("rst_man_big", 32'(man_big), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        for (int k = 0; k < NV; k++) begin
            single(k);
        end

        // Stream of four pairs with out_ready low on cycles 2..6.
        begin
            int  idx = 0;
            int  oidx = 0;
            bit  drop_seen = 0;
            bit  seen_out = 0;
            bit  prev_stall = 0;
            logic [7:0]  sv_diff;
            logic [26:0] sv_al;
            logic [23:0] sv_big;
            for (int c = 0; c < 40 && oidx < 4; c++) begin
                @(negedge clk);
                out_ready = !(c >= 2 && c <= 6);
                if (idx < 4) begin
                    drive(idx);
                    in_valid = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
                #1;
                if (prev_stall) begin
                    chk("stall_hold_diff", 32'(diff), 32'(sv_diff));
                    chk("stall_hold_al", 32'(man_small_al), 32'(sv_al));
                    chk("stall_hold_big", 32'(man_big), 32'(sv_big));
                end
                if (!in_ready && !drop_seen) begin
                    drop_seen = 1;
                    chk("stream_drop_after", idx, 2);
                end
                if (seen_out) begin
                    chk("stream_no_gap", 32'(out_valid), 32'd1);
                end
                if (out_valid && out_ready) begin
                    check_out(oidx, "stream");
                    oidx++;
                    seen_out = 1;
                end
                prev_stall = out_valid && !out_ready;
                sv_diff = diff;
                sv_al   = man_small_al;
                sv_big  = man_big;
                if (in_valid && in_ready) idx++;
                @(posedge clk);
            end
            chk("stream_drop_seen", 32'(drop_seen), 32'd1);
            chk("stream_all_out", oidx, 4);
        end

        // Reset with two pairs in flight.
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        drive(0);
        in_valid = 1'b1;
        @(negedge clk);
        drive(1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("rst2_pre_valid", 32'(out_valid), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("rst2_async_valid", 32'(out_valid), 32'd0);
        chk("rst2_async_diff", 32'(diff), 32'd0);
        chk("rst2_async_al", 32'(man_small_al), 32'd0);
        chk("rst2_async_emax", 32'(exp_max), 32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("rst2_no_stale", 32'(out_valid), 32'd0);
        end
        single(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
